// File: rtl/gelato_operand_collector_unit_if.sv
// Bus bundle for one operand collector entry: issue, RF-arbiter request,
// bank read responses and execution dispatch.
interface gelato_operand_collector_unit_if #(
  parameter int unsigned BANK_NUM   = 4,
  parameter int unsigned RS_NUM     = 4,
  parameter int unsigned REG_NUM_W  = 8,
  parameter int unsigned WARP_NUM_W = 5,
  parameter int unsigned COLL_W     = 2,
  parameter int unsigned RS_W       = 2,
  parameter int unsigned WARP_REG_W = 1024,
  parameter int unsigned INST_W     = 64
);
  logic                           issue_valid;
  logic                           issue_ready;
  logic [WARP_NUM_W-1:0]          issue_warp_num;
  logic [INST_W-1:0]              issue_inst;
  logic [RS_NUM*REG_NUM_W-1:0]    issue_reg_num;
  logic [RS_NUM-1:0]              issue_reg_valid;

  logic                           req_entry_valid;
  logic [WARP_NUM_W-1:0]          req_warp_num;
  logic [RS_NUM*REG_NUM_W-1:0]    req_reg_num;
  logic [RS_NUM-1:0]              req_reg_valid;

  logic [BANK_NUM-1:0]            rsp_data_valid;
  logic [BANK_NUM*COLL_W-1:0]     rsp_collector_index;
  logic [BANK_NUM*RS_W-1:0]       rsp_reg_index;
  logic [BANK_NUM*WARP_REG_W-1:0] rsp_data;

  logic                           dispatch_valid;
  logic                           dispatch_ready;
  logic [WARP_NUM_W-1:0]          dispatch_warp_num;
  logic [INST_W-1:0]              dispatch_inst;
  logic [RS_NUM*WARP_REG_W-1:0]   dispatch_operands;

  // Driver side: issue stage, RF banks and execution unit.
  modport master (
    output issue_valid, issue_warp_num, issue_inst, issue_reg_num, issue_reg_valid,
    output rsp_data_valid, rsp_collector_index, rsp_reg_index, rsp_data,
    output dispatch_ready,
    input  issue_ready,
    input  req_entry_valid, req_warp_num, req_reg_num, req_reg_valid,
    input  dispatch_valid, dispatch_warp_num, dispatch_inst, dispatch_operands
  );

  // Collector entry side.
  modport slave (
    input  issue_valid, issue_warp_num, issue_inst, issue_reg_num, issue_reg_valid,
    input  rsp_data_valid, rsp_collector_index, rsp_reg_index, rsp_data,
    input  dispatch_ready,
    output issue_ready,
    output req_entry_valid, req_warp_num, req_reg_num, req_reg_valid,
    output dispatch_valid, dispatch_warp_num, dispatch_inst, dispatch_operands
  );
endinterface

// File: rtl/gelato_operand_collector_unit.sv
// One operand collector entry: latches an issued instruction, requests its
// source registers, gathers tagged bank responses and dispatches the operand set.
module gelato_operand_collector_unit #(
  parameter int unsigned COLLECTOR_ID = 0,
  parameter int unsigned BANK_NUM     = 4,
  parameter int unsigned RS_NUM       = 4,
  parameter int unsigned REG_NUM_W    = 8,
  parameter int unsigned WARP_NUM_W   = 5,
  parameter int unsigned COLL_W       = 2,
  parameter int unsigned RS_W         = 2,
  parameter int unsigned WARP_REG_W   = 1024,
  parameter int unsigned INST_W       = 64
) (
  input logic clk,
  input logic rst,
  gelato_operand_collector_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPATCH = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [WARP_NUM_W-1:0]       r_warp_num;
  logic [INST_W-1:0]           r_inst;
  logic [RS_NUM*REG_NUM_W-1:0] r_reg_num;
  logic [RS_NUM-1:0]           r_pending;
  logic [WARP_REG_W-1:0]       r_operands [RS_NUM];

  logic [RS_W-1:0]             w_lane_slot [BANK_NUM];
  logic [BANK_NUM-1:0]         w_lane_hit;
  logic [RS_NUM-1:0]           w_slot_hit;
  logic [WARP_REG_W-1:0]       w_slot_data [RS_NUM];
  logic [RS_NUM-1:0]           w_pending_nxt;

  logic                        w_issue_ready;
  logic                        w_issue_accept;
  logic                        w_req_entry_valid;
  logic [WARP_NUM_W-1:0]       w_req_warp_num;
  logic [RS_NUM*REG_NUM_W-1:0] w_req_reg_num;
  logic [RS_NUM-1:0]           w_req_reg_valid;
  logic                        w_dispatch_valid;
  logic [WARP_NUM_W-1:0]       w_dispatch_warp_num;
  logic [INST_W-1:0]           w_dispatch_inst;
  logic [RS_NUM*WARP_REG_W-1:0] w_dispatch_operands;

  assign w_issue_accept = bus.issue_valid & w_issue_ready;

  // Lane hit detection; lanes scanned high-to-low so the lowest lane wins a shared slot.
  always_comb begin
    w_lane_hit = '0;
    w_slot_hit = '0;
    for (int k = 0; k < int'(RS_NUM); k++) w_slot_data[k] = '0;
    for (int b = 0; b < int'(BANK_NUM); b++) begin
      w_lane_slot[b] = bus.rsp_reg_index[b*RS_W +: RS_W];
      w_lane_hit[b]  = (r_state == S_COLLECT) && bus.rsp_data_valid[b] &&
                       (bus.rsp_collector_index[b*COLL_W +: COLL_W] == COLL_W'(COLLECTOR_ID)) &&
                       r_pending[w_lane_slot[b]];
    end
    for (int b = int'(BANK_NUM) - 1; b >= 0; b--) begin
      if (w_lane_hit[b]) begin
        w_slot_hit[w_lane_slot[b]]  = 1'b1;
        w_slot_data[w_lane_slot[b]] = bus.rsp_data[b*WARP_REG_W +: WARP_REG_W];
      end
    end
    w_pending_nxt = r_pending & ~w_slot_hit;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.issue_valid)
          w_state_nxt = (|bus.issue_reg_valid) ? S_COLLECT : S_DISPATCH;
      end
      S_COLLECT: begin
        if (w_pending_nxt == '0) w_state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (bus.dispatch_ready) begin
          if (bus.issue_valid)
            w_state_nxt = (|bus.issue_reg_valid) ? S_COLLECT : S_DISPATCH;
          else
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state and latched data.
  always_comb begin
    w_issue_ready       = 1'b0;
    w_req_entry_valid   = 1'b0;
    w_req_warp_num      = '0;
    w_req_reg_num       = '0;
    w_req_reg_valid     = '0;
    w_dispatch_valid    = 1'b0;
    w_dispatch_warp_num = '0;
    w_dispatch_inst     = '0;
    w_dispatch_operands = '0;
    unique case (r_state)
      S_IDLE: w_issue_ready = 1'b1;
      S_COLLECT: begin
        w_req_entry_valid = 1'b1;
        w_req_warp_num    = r_warp_num;
        w_req_reg_num     = r_reg_num;
        w_req_reg_valid   = r_pending;
      end
      S_DISPATCH: begin
        w_issue_ready       = bus.dispatch_ready;
        w_dispatch_valid    = 1'b1;
        w_dispatch_warp_num = r_warp_num;
        w_dispatch_inst     = r_inst;
        for (int k = 0; k < int'(RS_NUM); k++)
          w_dispatch_operands[k*WARP_REG_W +: WARP_REG_W] = r_operands[k];
      end
      default: ;
    endcase
  end

  // Instruction latch and operand collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warp_num <= '0;
      r_inst     <= '0;
      r_reg_num  <= '0;
      r_pending  <= '0;
      for (int k = 0; k < int'(RS_NUM); k++) r_operands[k] <= '0;
    end else if (w_issue_accept) begin
      r_warp_num <= bus.issue_warp_num;
      r_inst     <= bus.issue_inst;
      r_reg_num  <= bus.issue_reg_num;
      r_pending  <= bus.issue_reg_valid;
      for (int k = 0; k < int'(RS_NUM); k++) r_operands[k] <= '0;
    end else if (r_state == S_COLLECT) begin
      r_pending <= w_pending_nxt;
      for (int k = 0; k < int'(RS_NUM); k++)
        if (w_slot_hit[k]) r_operands[k] <= w_slot_data[k];
    end
  end

  assign bus.issue_ready       = w_issue_ready;
  assign bus.req_entry_valid   = w_req_entry_valid;
  assign bus.req_warp_num      = w_req_warp_num;
  assign bus.req_reg_num       = w_req_reg_num;
  assign bus.req_reg_valid     = w_req_reg_valid;
  assign bus.dispatch_valid    = w_dispatch_valid;
  assign bus.dispatch_warp_num = w_dispatch_warp_num;
  assign bus.dispatch_inst     = w_dispatch_inst;
  assign bus.dispatch_operands = w_dispatch_operands;

endmodule

// File: tb/tb_gelato_operand_collector_unit.sv
// Directed self-checking bench for gelato_operand_collector_unit.
module tb_gelato_operand_collector_unit;

  localparam int unsigned W = 1024;

  localparam logic [W-1:0] D0 = {32{32'h0D0D_1111}};
  localparam logic [W-1:0] D1 = {32{32'h0D0D_2222}};
  localparam logic [W-1:0] D2 = {32{32'h0D0D_3333}};
  localparam logic [W-1:0] DA = {32{32'hAAAA_AAAA}};
  localparam logic [W-1:0] DB = {32{32'hBBBB_BBBB}};
  localparam logic [W-1:0] DC = {32{32'hCCCC_CCCC}};
  localparam logic [W-1:0] DE = {32{32'hEEEE_EEEE}};
  localparam logic [W-1:0] DJ = {32{32'h5A5A_5A5A}};
  localparam logic [W-1:0] ZERO = '0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  gelato_operand_collector_unit_if bus ();

  gelato_operand_collector_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rsp();
    bus.rsp_data_valid      = '0;
    bus.rsp_collector_index = '0;
    bus.rsp_reg_index       = '0;
    bus.rsp_data            = '0;
  endtask

  task automatic lane(input int b, input logic [1:0] coll, input logic [1:0] slot,
                      input logic [W-1:0] data);
    bus.rsp_data_valid[b]           = 1'b1;
    bus.rsp_collector_index[b*2 +: 2] = coll;
    bus.rsp_reg_index[b*2 +: 2]     = slot;
    bus.rsp_data[b*W +: W]          = data;
  endtask

  function automatic logic [W-1:0] op(input int k);
    return bus.dispatch_operands[k*W +: W];
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.issue_valid     = 1'b0;
    bus.issue_warp_num  = '0;
    bus.issue_inst      = '0;
    bus.issue_reg_num   = '0;
    bus.issue_reg_valid = '0;
    bus.dispatch_ready  = 1'b0;
    clear_rsp();
    tick();
    tick();

    check_eq("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    check_eq("rst_req_valid", 64'(bus.req_entry_valid), 64'd0);
    check_eq("rst_disp_valid", 64'(bus.dispatch_valid), 64'd0);
    check_eq("rst_operands_zero", 64'(bus.dispatch_operands == '0), 64'd1);
    rst = 1'b0;
    tick();

    // Three-operand issue, slot 3 unused.
    bus.issue_valid     = 1'b1;
    bus.issue_warp_num  = 5'd7;
    bus.issue_inst      = 64'hDEAD_BEEF_0000_0001;
    bus.issue_reg_num   = {8'd0, 8'd9, 8'd6, 8'd5};
    bus.issue_reg_valid = 4'b0111;
    tick();
    bus.issue_valid = 1'b0;
    check_eq("a_req_valid", 64'(bus.req_entry_valid), 64'd1);
    check_eq("a_req_reg_valid", 64'(bus.req_reg_valid), 64'h7);
    check_eq("a_req_warp", 64'(bus.req_warp_num), 64'd7);
    check_eq("a_req_reg_num", 64'(bus.req_reg_num), 64'h0009_0605);
    check_eq("a_issue_ready", 64'(bus.issue_ready), 64'd0);

    lane(1, 2'd0, 2'd0, D0);
    lane(2, 2'd0, 2'd1, D1);
    tick();
    clear_rsp();
    check_eq("a_pending_t1", 64'(bus.req_reg_valid), 64'h4);
    check_eq("a_no_disp_t1", 64'(bus.dispatch_valid), 64'd0);

    lane(0, 2'd1, 2'd2, DJ);
    tick();
    clear_rsp();
    check_eq("foreign_pending", 64'(bus.req_reg_valid), 64'h4);
    check_eq("foreign_no_disp", 64'(bus.dispatch_valid), 64'd0);

    lane(1, 2'd0, 2'd2, D2);
    tick();
    clear_rsp();
    check_eq("a_disp_valid", 64'(bus.dispatch_valid), 64'd1);
    check_eq("a_req_off", 64'(bus.req_entry_valid), 64'd0);
    check_eq("a_req_reg_valid_off", 64'(bus.req_reg_valid), 64'd0);
    check_eq("a_op0", 64'(op(0) == D0), 64'd1);
    check_eq("a_op1", 64'(op(1) == D1), 64'd1);
    check_eq("a_op2", 64'(op(2) == D2), 64'd1);
    check_eq("a_op3_zero", 64'(op(3) == ZERO), 64'd1);
    check_eq("a_disp_warp", 64'(bus.dispatch_warp_num), 64'd7);
    check_eq("a_disp_inst", bus.dispatch_inst, 64'hDEAD_BEEF_0000_0001);

    // Backpressure; a stray response during dispatch must be ignored.
    lane(0, 2'd0, 2'd0, DJ);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_disp_valid", 64'(bus.dispatch_valid), 64'd1);
      check_eq("bp_issue_ready", 64'(bus.issue_ready), 64'd0);
      check_eq("bp_op0", 64'(op(0) == D0), 64'd1);
      check_eq("bp_op2", 64'(op(2) == D2), 64'd1);
      check_eq("bp_warp", 64'(bus.dispatch_warp_num), 64'd7);
    end
    clear_rsp();

    // Back-to-back issue on the dispatch handshake.
    bus.dispatch_ready  = 1'b1;
    bus.issue_valid     = 1'b1;
    bus.issue_warp_num  = 5'd3;
    bus.issue_inst      = 64'h0000_0000_CAFE_0002;
    bus.issue_reg_num   = {8'd0, 8'd0, 8'h22, 8'h11};
    bus.issue_reg_valid = 4'b0011;
    #1;
    check_eq("b2b_issue_ready", 64'(bus.issue_ready), 64'd1);
    tick();
    bus.issue_valid    = 1'b0;
    bus.dispatch_ready = 1'b0;
    check_eq("b2b_req_valid", 64'(bus.req_entry_valid), 64'd1);
    check_eq("b2b_req_reg_valid", 64'(bus.req_reg_valid), 64'h3);
    check_eq("b2b_req_warp", 64'(bus.req_warp_num), 64'd3);
    check_eq("b2b_disp_off", 64'(bus.dispatch_valid), 64'd0);

    // Duplicate slot on lanes 0 and 3: lane 0 wins.
    lane(0, 2'd0, 2'd1, DA);
    lane(3, 2'd0, 2'd1, DB);
    tick();
    clear_rsp();
    check_eq("dup_pending", 64'(bus.req_reg_valid), 64'h1);
    lane(2, 2'd0, 2'd1, DC);
    tick();
    clear_rsp();
    check_eq("repeat_pending", 64'(bus.req_reg_valid), 64'h1);
    check_eq("repeat_no_disp", 64'(bus.dispatch_valid), 64'd0);
    lane(3, 2'd0, 2'd0, DE);
    tick();
    clear_rsp();
    check_eq("dup_disp_valid", 64'(bus.dispatch_valid), 64'd1);
    check_eq("dup_op1", 64'(op(1) == DA), 64'd1);
    check_eq("dup_op0", 64'(op(0) == DE), 64'd1);
    check_eq("dup_op2_cleared", 64'(op(2) == ZERO), 64'd1);
    check_eq("dup_inst", bus.dispatch_inst, 64'h0000_0000_CAFE_0002);

    bus.dispatch_ready = 1'b1;
    tick();
    bus.dispatch_ready = 1'b0;
    check_eq("idle_issue_ready", 64'(bus.issue_ready), 64'd1);
    check_eq("idle_disp_off", 64'(bus.dispatch_valid), 64'd0);

    // Zero-operand instruction.
    bus.issue_valid     = 1'b1;
    bus.issue_warp_num  = 5'd9;
    bus.issue_inst      = 64'h1234;
    bus.issue_reg_num   = {8'd1, 8'd2, 8'd3, 8'd4};
    bus.issue_reg_valid = 4'b0000;
    tick();
    bus.issue_valid = 1'b0;
    check_eq("zero_disp_valid", 64'(bus.dispatch_valid), 64'd1);
    check_eq("zero_req_off", 64'(bus.req_entry_valid), 64'd0);
    check_eq("zero_operands", 64'(bus.dispatch_operands == '0), 64'd1);
    check_eq("zero_warp", 64'(bus.dispatch_warp_num), 64'd9);
    bus.dispatch_ready = 1'b1;
    tick();
    bus.dispatch_ready = 1'b0;
    check_eq("zero_back_idle", 64'(bus.issue_ready), 64'd1);
    check_eq("zero_req_never", 64'(bus.req_entry_valid), 64'd0);

    // Asynchronous reset in the middle of collection.
    bus.issue_valid     = 1'b1;
    bus.issue_warp_num  = 5'd4;
    bus.issue_reg_valid = 4'b0001;
    tick();
    bus.issue_valid = 1'b0;
    check_eq("mid_req_valid", 64'(bus.req_entry_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    check_eq("mid_rst_req_off", 64'(bus.req_entry_valid), 64'd0);
    check_eq("mid_rst_disp_off", 64'(bus.dispatch_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_idle", 64'(bus.issue_ready), 64'd1);
    check_eq("post_rst_req_off", 64'(bus.req_entry_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
